// File: rtl/wb_commit_unit.sv
// wb_commit_unit: buffers execute-stage results in a FIFO and retires one per cycle into an 8x16 register file
module wb_commit_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  logic [2:0]       in_rd,
  input  logic [1:0]       in_kind,
  input  logic             wb_stall,
  input  logic [2:0]       raddr_a,
  output logic [15:0]      rdata_a,
  output logic             pend_a,
  input  logic [2:0]       raddr_b,
  output logic [15:0]      rdata_b,
  output logic             pend_b,
  output logic [PTR_W:0]   count,
  output logic [15:0]      commit_cnt
);
  logic [15:0]      regs_q [8];
  logic [15:0]      regs_d [8];
  logic [15:0]      ent_res_q [DEPTH];
  logic [15:0]      ent_res_d [DEPTH];
  logic [2:0]       ent_rd_q [DEPTH];
  logic [2:0]       ent_rd_d [DEPTH];
  logic [1:0]       ent_kind_q [DEPTH];
  logic [1:0]       ent_kind_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [15:0]      commit_cnt_q, commit_cnt_d;
  logic             push, pop;
  assign in_ready   = count_q < (PTR_W+1)'(DEPTH);
  assign push       = in_valid & in_ready;
  assign pop        = (count_q != '0) & ~wb_stall;
  assign count      = count_q;
  assign commit_cnt = commit_cnt_q;
  assign rdata_a    = regs_q[raddr_a];
  assign rdata_b    = regs_q[raddr_b];
  always_comb begin
    regs_d       = regs_q;
    ent_res_d    = ent_res_q;
    ent_rd_d     = ent_rd_q;
    ent_kind_d   = ent_kind_q;
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    commit_cnt_d = pop ? commit_cnt_q + 16'd1 : commit_cnt_q;
    if (push) begin
      ent_res_d[wr_ptr_q]  = in_result;
      ent_rd_d[wr_ptr_q]   = in_rd;
      ent_kind_d[wr_ptr_q] = in_kind;
    end
    if (pop && ent_kind_q[rd_ptr_q] == 2'd1) regs_d[ent_rd_q[rd_ptr_q]] = ent_res_q[rd_ptr_q];
    if (pop && ent_kind_q[rd_ptr_q] == 2'd2) regs_d[7] = {14'b0, ent_res_q[rd_ptr_q][1:0]};
  end
  // an entry is occupied when its distance from the head is below the occupancy
  always_comb begin
    logic [PTR_W-1:0] off;
    logic             occ, has_tgt;
    logic [2:0]       tgt;
    pend_a  = 1'b0;
    pend_b  = 1'b0;
    off     = '0;
    occ     = 1'b0;
    has_tgt = 1'b0;
    tgt     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off     = PTR_W'(i) - rd_ptr_q;
      occ     = {1'b0, off} < count_q;
      has_tgt = (ent_kind_q[i] == 2'd1) || (ent_kind_q[i] == 2'd2);
      tgt     = (ent_kind_q[i] == 2'd2) ? 3'd7 : ent_rd_q[i];
      pend_a  = pend_a | (occ & has_tgt & (tgt == raddr_a));
      pend_b  = pend_b | (occ & has_tgt & (tgt == raddr_b));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_res_q[i]  <= '0;
        ent_rd_q[i]   <= '0;
        ent_kind_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      commit_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      ent_res_q    <= ent_res_d;
      ent_rd_q     <= ent_rd_d;
      ent_kind_q   <= ent_kind_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed scenario tests with hand-computed expectations for wb_commit_unit
module tb_wb_commit_unit;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, wb_stall = 0;
  logic [15:0] in_result = 0;
  logic [2:0]  in_rd = 0, raddr_a = 0, raddr_b = 0;
  logic [1:0]  in_kind = 0;
  logic [15:0] rdata_a, rdata_b, commit_cnt;
  logic        pend_a, pend_b;
  logic [2:0]  count;
  int          vecs = 0, errs = 0;

  wb_commit_unit #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_kind(in_kind), .wb_stall(wb_stall),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .pend_a(pend_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b), .pend_b(pend_b),
    .count(count), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    vecs++; if (commit_cnt !== 16'd0) begin errs++; $display("FAIL reset_commit got %0d exp 0", commit_cnt); end
    vecs++; if (pend_a !== 1'b0 || pend_b !== 1'b0) begin errs++; $display("FAIL reset_pend got %b%b exp 00", pend_a, pend_b); end
    step; step;
    rst = 0;
    step;
  endtask

  task automatic test_basic;
    raddr_a = 3; in_valid = 1; in_result = 16'h1234; in_rd = 3; in_kind = 1;
    #1;
    vecs++; if (pend_a !== 1'b0) begin errs++; $display("FAIL basic_pend_incoming got %b exp 0", pend_a); end
    step;
    in_valid = 0;
    vecs++; if (pend_a !== 1'b1) begin errs++; $display("FAIL basic_pend_buffered got %b exp 1", pend_a); end
    vecs++; if (rdata_a !== 16'h0000) begin errs++; $display("FAIL basic_early got %h exp 0000", rdata_a); end
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL basic_count got %0d exp 1", count); end
    step;
    vecs++; if (rdata_a !== 16'h1234) begin errs++; $display("FAIL basic_data got %h exp 1234", rdata_a); end
    vecs++; if (pend_a !== 1'b0) begin errs++; $display("FAIL basic_pend_clear got %b exp 0", pend_a); end
    vecs++; if (commit_cnt !== 16'd1) begin errs++; $display("FAIL basic_commit got %0d exp 1", commit_cnt); end
  endtask

  task automatic test_flags;
    logic [15:0] codes [3];
    codes[0] = 16'd2; codes[1] = 16'd1; codes[2] = 16'd0;
    raddr_a = 7; in_kind = 2; in_rd = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      in_result = (i < 3) ? codes[i] : 16'h0;
      step;
      if (i >= 1) begin
        vecs++; if (rdata_a !== codes[i-1]) begin errs++; $display("FAIL flags_seq%0d got %h exp %h", i-1, rdata_a, codes[i-1]); end
      end
    end
    in_valid = 1; in_result = 16'hFFFF;
    step;
    in_valid = 0;
    step;
    vecs++; if (rdata_a !== 16'h0003) begin errs++; $display("FAIL flags_trunc got %h exp 0003", rdata_a); end
    vecs++; if (commit_cnt !== 16'd5) begin errs++; $display("FAIL flags_commit got %0d exp 5", commit_cnt); end
  endtask

  task automatic test_full_stall;
    wb_stall = 1; in_kind = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_rd = 3'(i + 1); in_result = 16'(16'hA0 + i);
      #1;
      if (i == 4) begin
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %b exp 0", in_ready); end
      end
      step;
    end
    in_valid = 0;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL full_count got %0d exp 4", count); end
    vecs++; if (commit_cnt !== 16'd5) begin errs++; $display("FAIL full_stall_commit got %0d exp 5", commit_cnt); end
    wb_stall = 0;
    step;
    vecs++; if (in_ready !== 1'b1 || count !== 3'd3) begin errs++; $display("FAIL full_release got ready=%b count=%0d exp ready=1 count=3", in_ready, count); end
    step; step; step;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL full_drain got %0d exp 0", count); end
    vecs++; if (commit_cnt !== 16'd9) begin errs++; $display("FAIL full_commit got %0d exp 9", commit_cnt); end
    for (int r = 1; r <= 4; r++) begin
      raddr_a = 3'(r);
      #1;
      vecs++; if (rdata_a !== 16'(16'hA0 + r - 1)) begin errs++; $display("FAIL full_reg%0d got %h exp %h", r, rdata_a, 16'(16'hA0 + r - 1)); end
    end
    raddr_b = 5;
    #1;
    vecs++; if (rdata_b !== 16'h0000) begin errs++; $display("FAIL full_rejected got %h exp 0000", rdata_b); end
  endtask

  task automatic test_order;
    logic [15:0] vals [4];
    logic [1:0]  kinds [4];
    vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'hFFFF; vals[3] = 16'hEEEE;
    kinds[0] = 1; kinds[1] = 1; kinds[2] = 0; kinds[3] = 3;
    wb_stall = 1; raddr_b = 5; in_rd = 5;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_result = vals[i]; in_kind = kinds[i];
      step;
    end
    in_valid = 0;
    vecs++; if (pend_b !== 1'b1 || count !== 3'd4) begin errs++; $display("FAIL order_pend got pend=%b count=%0d exp pend=1 count=4", pend_b, count); end
    wb_stall = 0;
    step;
    vecs++; if (rdata_b !== 16'h0001 || pend_b !== 1'b1) begin errs++; $display("FAIL order_first got %h/%b exp 0001/1", rdata_b, pend_b); end
    step;
    vecs++; if (rdata_b !== 16'h0002 || pend_b !== 1'b0) begin errs++; $display("FAIL order_second got %h/%b exp 0002/0", rdata_b, pend_b); end
    step; step;
    vecs++; if (rdata_b !== 16'h0002) begin errs++; $display("FAIL order_nowrite got %h exp 0002", rdata_b); end
    vecs++; if (commit_cnt !== 16'd13 || count !== 3'd0) begin errs++; $display("FAIL order_commit got %0d/%0d exp 13/0", commit_cnt, count); end
  endtask

  task automatic test_wrap;
    in_kind = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_rd = 3'(i % 8); in_result = 16'(16'h100 + i);
      step;
      vecs++; if (count !== 3'd1) begin errs++; $display("FAIL wrap_count%0d got %0d exp 1", i, count); end
    end
    in_valid = 0;
    step;
    vecs++; if (commit_cnt !== 16'd23 || count !== 3'd0) begin errs++; $display("FAIL wrap_commit got %0d/%0d exp 23/0", commit_cnt, count); end
    for (int r = 0; r < 8; r++) begin
      raddr_a = 3'(r);
      #1;
      vecs++; if (rdata_a !== ((r < 2) ? 16'(16'h108 + r) : 16'(16'h100 + r))) begin
        errs++; $display("FAIL wrap_reg%0d got %h exp %h", r, rdata_a, (r < 2) ? 16'(16'h108 + r) : 16'(16'h100 + r));
      end
    end
  endtask

  task automatic test_reset_mid;
    wb_stall = 1; in_kind = 1; in_rd = 2; raddr_a = 2; raddr_b = 7;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_result = 16'(16'hD00 + i);
      step;
    end
    in_valid = 0;
    vecs++; if (count !== 3'd3 || pend_a !== 1'b1) begin errs++; $display("FAIL mid_setup got %0d/%b exp 3/1", count, pend_a); end
    #2 rst = 1;
    #1;
    vecs++; if (count !== 3'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL mid_count got %0d/%b exp 0/1", count, in_ready); end
    vecs++; if (pend_a !== 1'b0 || pend_b !== 1'b0) begin errs++; $display("FAIL mid_pend got %b%b exp 00", pend_a, pend_b); end
    vecs++; if (commit_cnt !== 16'd0) begin errs++; $display("FAIL mid_commit got %0d exp 0", commit_cnt); end
    for (int r = 0; r < 8; r++) begin
      raddr_a = 3'(r);
      #1;
      vecs++; if (rdata_a !== 16'h0000) begin errs++; $display("FAIL mid_reg%0d got %h exp 0000", r, rdata_a); end
    end
    step;
    rst = 0; wb_stall = 0; raddr_a = 2;
    step; step;
    vecs++; if (commit_cnt !== 16'd0 || rdata_a !== 16'h0000) begin errs++; $display("FAIL mid_discard got %0d/%h exp 0/0000", commit_cnt, rdata_a); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_flags;
    test_full_stall;
    test_order;
    test_wrap;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Consumer end of the execute-stage result interface. Accepts ALU results tagged with a destination and a write kind, and buffers them in a DEPTH-entry FIFO.
- Retires at most one entry per cycle into an 8x16 architectural register file; r7 is the compare-flags register.
- Provides two combinational read ports with per-port pending (hazard) indication for issue logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  result beat offered
- in_ready  output  1  FIFO can accept a beat
- in_result  input  16  ALU result; for kind 2, a flag code (0 less, 1 equal, 2 greater)
- in_rd  input  3  destination register, used for kind 1
- in_kind  input  2  0 no write, 1 write rd, 2 write flags to r7, 3 reserved (treated as 0)
- wb_stall  input  1  inhibits retirement this cycle
- raddr_a  input  3  read port A address
- rdata_a  output  16  committed value of raddr_a
- pend_a  output  1  a buffered entry will write raddr_a
- raddr_b  input  3  read port B address
- rdata_b  output  16  committed value of raddr_b
- pend_b  output  1  a buffered entry will write raddr_b
- count  output  PTR_W+1  FIFO occupancy
- commit_cnt  output  16  retired-entry counter, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, immediate):
  - all 8 registers = 0; FIFO empty; rd/wr pointers = 0
  - count = 0; commit_cnt = 0; in_ready = 1; pend_a = pend_b = 0
  - Reset asserted mid-operation discards all buffered entries; none retire.
- Push: on (in_valid & in_ready) the entry {result, rd, kind} is written at wr_ptr, and wr_ptr increments mod DEPTH.
- in_ready = (count < DEPTH). It is registered-state only and does not depend on same-cycle retirement, so a full FIFO rejects even when a pop occurs that cycle.
- Retire: when count != 0 and !wb_stall, the head entry retires at the clock edge and rd_ptr increments.
  - kind 1: reg[rd] <= result. r0 is a normal register; rd = 7 overwrites the flags.
  - kind 2: reg[7] <= {14'b0, result[1:0]}. Code 3 is written as 3; there is no checking.
  - kind 0 or 3: no register write, but the entry still retires and is still counted.
  - commit_cnt increments on every retirement.
- Simultaneous push and retire: count is unchanged; both pointers advance.
- Empty FIFO with wb_stall: no effect. Stall with a non-empty FIFO: hold all state, but still accept pushes while not full.
- Latency:
  - A beat pushed in cycle N is at the head in cycle N+1 at the earliest, if the FIFO was empty.
  - Its register write is visible on rdata at N+2 (one cycle of buffering plus one cycle of retire).
- Read ports:
  - rdata_x = reg[raddr_x], combinational, committed state only; there is no bypass from the FIFO.
  - pend_x = OR over all occupied entries of (target == raddr_x).
  - target is rd for kind 1, 7 for kind 2, none for kind 0/3.
  - The incoming in_valid beat is not included; pend reflects registered FIFO contents only.
  - The head entry counts as pending until the edge where it retires.
- Write ordering: entries to the same register retire in push order, so the last pushed value wins.
- Pointer wrap: pointers wrap mod DEPTH; full vs empty is distinguished by count, not by pointer equality.

Test Plan:
- Reset: assert rst mid-stream with 3 entries buffered -> count=0, in_ready=1, all rdata=0, pend=0, commit_cnt=0 immediately, with no clock edge required.
- Basic write: push {16'h1234, rd=3, kind=1} with wb_stall=0 -> pend_a (raddr_a=3) =1 for one cycle, then rdata_a=16'h1234 two edges after the push, pend_a=0, commit_cnt=1.
- Flags: push kind=2 with results 2, 1, 0 back-to-back -> r7 reads 2, 1, 0 on successive cycles; push kind=2 result 16'hFFFF -> r7=16'h0003.
- Full/stall: hold wb_stall=1 and push 5 beats (DEPTH=4) -> in_ready=0 after the 4th, 5th beat not accepted, count=4; release stall -> 4 retirements over 4 cycles, in_ready returns 1 the cycle after the first retire.
- Ordering/hazard: push rd=5 values 16'h0001 then 16'h0002 under stall -> pend_b(raddr_b=5)=1 until both retire, final rdata_b=16'h0002; a kind=0 entry retires with no register change and commit_cnt+1.
- Wrap: stream 10 beats at full rate with no stall, targeting rd = i mod 8 -> every value is committed in order, pointers wrap cleanly, commit_cnt=10.
